// File: rtl/inst_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : inst_decode_pipe
// Purpose  : Flow-controlled PE instruction decoder with a 2-entry skid
//            buffer. Splits the instruction word into fn and the destination
//            and source (name,index) operand fields, with a valid bit for
//            each operand.
// Options  : INST_DECODE_HAZARD_EN - when defined, the block records the
//            destination set of the last handed-off instruction. It raises
//            a RAW hazard flag against that set.
// Revision : 1.0 - initial release
// ============================================================================
module inst_decode_pipe #(
  parameter int DEST_NUM  = 3,
  parameter int SRC_NUM   = 3,
  parameter int FN_LEN    = 3,
  parameter int NAME_LEN  = 3,
  parameter int INDEX_LEN = 8,
  parameter int CNT_LEN   = 16,
  parameter int INST_LEN  = FN_LEN + (DEST_NUM + SRC_NUM) * (NAME_LEN + INDEX_LEN)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic [INST_LEN-1:0]           in_inst,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FN_LEN-1:0]             fn,
  output logic [DEST_NUM*NAME_LEN-1:0]  dest_name,
  output logic [DEST_NUM*INDEX_LEN-1:0] dest_index,
  output logic [DEST_NUM-1:0]           dest_v,
  output logic [SRC_NUM*NAME_LEN-1:0]   src_name,
  output logic [SRC_NUM*INDEX_LEN-1:0]  src_index,
  output logic [SRC_NUM-1:0]            src_v,
  output logic                          hazard,
  output logic [CNT_LEN-1:0]            inst_count
);

  localparam int OP_LEN = NAME_LEN + INDEX_LEN;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [INST_LEN-1:0] r_head;
  logic [INST_LEN-1:0] r_skid;
  logic [CNT_LEN-1:0]  r_count;

  logic w_push;
  logic w_pop;
  logic w_load_head_in;
  logic w_load_head_skid;
  logic w_load_skid;

  // Unmasked fields of the head entry
  logic [FN_LEN-1:0]             w_fn_raw;
  logic [DEST_NUM*NAME_LEN-1:0]  w_dest_name_raw;
  logic [DEST_NUM*INDEX_LEN-1:0] w_dest_index_raw;
  logic [DEST_NUM-1:0]           w_dest_v_raw;
  logic [SRC_NUM*NAME_LEN-1:0]   w_src_name_raw;
  logic [SRC_NUM*INDEX_LEN-1:0]  w_src_index_raw;
  logic [SRC_NUM-1:0]            w_src_v_raw;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // State register: occupancy of the head/skid pair
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides any concurrent push/pop
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_push) w_state_next = S_ONE;
      S_ONE: begin
        if (w_push && !w_pop)      w_state_next = S_TWO;
        else if (w_pop && !w_push) w_state_next = S_EMPTY;
      end
      S_TWO:   if (w_pop) w_state_next = S_ONE;
      default: w_state_next = S_EMPTY;
    endcase
    if (flush) w_state_next = S_EMPTY;
  end

  // Handshake outputs decoded from the state register only (no comb paths from inputs)
  always_comb begin
    out_valid = (r_state == S_ONE) || (r_state == S_TWO);
    in_ready  = (r_state != S_TWO);
  end

  // Push lands in the head when it is (or is becoming) free, otherwise in the skid
  assign w_load_head_in   = w_push & ((r_state == S_EMPTY) | ((r_state == S_ONE) & w_pop));
  assign w_load_skid      = w_push & (r_state == S_ONE) & ~w_pop;
  assign w_load_head_skid = w_pop & (r_state == S_TWO);

  // Entry storage; contents behind an empty state are don't-care because outputs are masked
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head_in)        r_head <= in_inst;
      else if (w_load_head_skid) r_head <= r_skid;
      if (w_load_skid)           r_skid <= in_inst;
    end
  end

  // Handoff counter; a pop in the same cycle as flush still counts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (w_pop) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign inst_count = r_count;
  assign w_fn_raw   = r_head[INST_LEN-1 -: FN_LEN];

  // Destination i sits just below fn, dest0 highest
  for (genvar i = 0; i < DEST_NUM; i++) begin : g_dest
    localparam int BASE = (SRC_NUM + DEST_NUM - 1 - i) * OP_LEN;
    assign w_dest_name_raw[i*NAME_LEN +: NAME_LEN]    = r_head[BASE+INDEX_LEN +: NAME_LEN];
    assign w_dest_index_raw[i*INDEX_LEN +: INDEX_LEN] = r_head[BASE +: INDEX_LEN];
    assign w_dest_v_raw[i] = |r_head[BASE+INDEX_LEN +: NAME_LEN];
  end

  // Source j below the destinations, src0 highest
  for (genvar j = 0; j < SRC_NUM; j++) begin : g_src
    localparam int BASE = (SRC_NUM - 1 - j) * OP_LEN;
    assign w_src_name_raw[j*NAME_LEN +: NAME_LEN]    = r_head[BASE+INDEX_LEN +: NAME_LEN];
    assign w_src_index_raw[j*INDEX_LEN +: INDEX_LEN] = r_head[BASE +: INDEX_LEN];
    assign w_src_v_raw[j] = |r_head[BASE+INDEX_LEN +: NAME_LEN];
  end

  assign fn         = w_fn_raw         & {FN_LEN{out_valid}};
  assign dest_name  = w_dest_name_raw  & {(DEST_NUM*NAME_LEN){out_valid}};
  assign dest_index = w_dest_index_raw & {(DEST_NUM*INDEX_LEN){out_valid}};
  assign dest_v     = w_dest_v_raw     & {DEST_NUM{out_valid}};
  assign src_name   = w_src_name_raw   & {(SRC_NUM*NAME_LEN){out_valid}};
  assign src_index  = w_src_index_raw  & {(SRC_NUM*INDEX_LEN){out_valid}};
  assign src_v      = w_src_v_raw      & {SRC_NUM{out_valid}};

`ifdef INST_DECODE_HAZARD_EN
  logic [DEST_NUM*NAME_LEN-1:0]  r_hist_name;
  logic [DEST_NUM*INDEX_LEN-1:0] r_hist_index;
  logic [DEST_NUM-1:0]           r_hist_v;
  logic [SRC_NUM*DEST_NUM-1:0]   w_hit;

  // History follows the head: it is updated on the same edge as the head,
  // so the flag is a pure function of registered state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist_name  <= '0;
      r_hist_index <= '0;
      r_hist_v     <= '0;
    end else if (flush) begin
      r_hist_name  <= '0;
      r_hist_index <= '0;
      r_hist_v     <= '0;
    end else if (w_pop) begin
      r_hist_name  <= w_dest_name_raw;
      r_hist_index <= w_dest_index_raw;
      r_hist_v     <= w_dest_v_raw;
    end
  end

  for (genvar j = 0; j < SRC_NUM; j++) begin : g_hz_src
    for (genvar i = 0; i < DEST_NUM; i++) begin : g_hz_dest
      assign w_hit[j*DEST_NUM+i] = w_src_v_raw[j] & r_hist_v[i]
        & (w_src_name_raw[j*NAME_LEN +: NAME_LEN] == r_hist_name[i*NAME_LEN +: NAME_LEN])
        & (w_src_index_raw[j*INDEX_LEN +: INDEX_LEN] == r_hist_index[i*INDEX_LEN +: INDEX_LEN]);
    end
  end

  assign hazard = out_valid & (|w_hit);
`else
  assign hazard = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_decode_pipe
// Purpose  : Directed self-checking bench for inst_decode_pipe (default
//            parameters). Hazard expectations follow INST_DECODE_HAZARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_decode_pipe;

  localparam int INST_LEN = 69;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic [68:0]   in_inst = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    fn;
  logic [8:0]    dest_name;
  logic [23:0]   dest_index;
  logic [2:0]    dest_v;
  logic [8:0]    src_name;
  logic [23:0]   src_index;
  logic [2:0]    src_v;
  logic          hazard;
  logic [15:0]   inst_count;

  int n_checks = 0;
  int n_err    = 0;

`ifdef INST_DECODE_HAZARD_EN
  localparam logic HZ_ON = 1'b1;
`else
  localparam logic HZ_ON = 1'b0;
`endif

  inst_decode_pipe dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .in_inst    (in_inst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fn         (fn),
    .dest_name  (dest_name),
    .dest_index (dest_index),
    .dest_v     (dest_v),
    .src_name   (src_name),
    .src_index  (src_index),
    .src_v      (src_v),
    .hazard     (hazard),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  // Word with fn, dest0, src0, src1; every other operand unused
  function automatic logic [68:0] mkw(input logic [2:0] f,
                                      input logic [2:0] d0n, input logic [7:0] d0i,
                                      input logic [2:0] s0n, input logic [7:0] s0i,
                                      input logic [2:0] s1n, input logic [7:0] s1i);
    return {f, d0n, d0i, 22'd0, s0n, s0i, s1n, s1i, 11'd0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_fn",        64'(fn),        64'd0);
    check("rst_dest_v",    64'(dest_v),    64'd0);
    check("rst_src_v",     64'(src_v),     64'd0);
    check("rst_hazard",    64'(hazard),    64'd0);
    check("rst_count",     64'(inst_count), 64'd0);
    #10 rstn = 1'b1;   // t=12, between edges
    tick();

    // ---------------- single word ----------------
    in_inst  = mkw(3'd5, 3'd1, 8'h10, 3'd2, 8'h20, 3'd0, 8'h00);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("w1_out_valid",  64'(out_valid),  64'd1);
    check("w1_fn",         64'(fn),         64'd5);
    check("w1_dest_v",     64'(dest_v),     64'b001);
    check("w1_src_v",      64'(src_v),      64'b001);
    check("w1_dest_name",  64'(dest_name),  64'h001);
    check("w1_dest_index", 64'(dest_index), 64'h000010);
    check("w1_src_name",   64'(src_name),   64'h002);
    check("w1_src_index",  64'(src_index),  64'h000020);
    check("w1_in_ready",   64'(in_ready),   64'd1);
    tick();
    check("w1_hold_fn",    64'(fn),         64'd5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("w1_pop_valid",  64'(out_valid),  64'd0);
    check("w1_pop_fn",     64'(fn),         64'd0);
    check("w1_pop_dest_v", 64'(dest_v),     64'd0);
    check("w1_pop_count",  64'(inst_count), 64'd1);

    // ---------------- backpressure: 3 words ----------------
    in_valid = 1'b1;
    in_inst  = mkw(3'd1, 3'd1, 8'h01, 3'd0, 8'h00, 3'd0, 8'h00);
    tick();
    check("bp_rdy_after1", 64'(in_ready), 64'd1);
    in_inst  = mkw(3'd2, 3'd1, 8'h02, 3'd0, 8'h00, 3'd0, 8'h00);
    tick();
    check("bp_rdy_after2", 64'(in_ready), 64'd0);
    in_inst  = mkw(3'd3, 3'd1, 8'h03, 3'd0, 8'h00, 3'd0, 8'h00);
    tick();
    check("bp_rdy_held",   64'(in_ready), 64'd0);
    check("bp_head_fn",    64'(fn),       64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_fn2",        64'(fn),       64'd2);
    check("bp_rdy_back",   64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_fn3",        64'(fn),         64'd3);
    check("bp_idx3",       64'(dest_index), 64'h000003);
    tick();
    out_ready = 1'b0;
    check("bp_drained",    64'(out_valid),  64'd0);
    check("bp_count",      64'(inst_count), 64'd4);

    // ---------------- streaming 100 words ----------------
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_inst = mkw(3'(i), 3'd4, 8'(i), 3'd0, 8'h00, 3'd0, 8'h00);
      tick();
      check("st_ready", 64'(in_ready), 64'd1);
      check("st_idx",   64'(dest_index), 64'(8'(i)));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("st_count", 64'(inst_count), 64'd104);
    check("st_empty", 64'(out_valid),  64'd0);

    // ---------------- flush in TWO ----------------
    in_valid = 1'b1;
    in_inst  = mkw(3'd6, 3'd1, 8'hA1, 3'd0, 8'h00, 3'd0, 8'h00);
    tick();
    in_inst  = mkw(3'd6, 3'd1, 8'hA2, 3'd0, 8'h00, 3'd0, 8'h00);
    tick();
    check("fl_two_rdy", 64'(in_ready), 64'd0);
    in_inst  = mkw(3'd7, 3'd1, 8'hA3, 3'd0, 8'h00, 3'd0, 8'h00);
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid",  64'(out_valid), 64'd0);
    check("fl_ready",  64'(in_ready),  64'd1);
    tick();
    check("fl_gone",   64'(out_valid), 64'd0);
    check("fl_count",  64'(inst_count), 64'd104);

    // flush in ONE with accepted push and concurrent pop
    in_valid = 1'b1;
    in_inst  = mkw(3'd6, 3'd1, 8'hB1, 3'd0, 8'h00, 3'd0, 8'h00);
    tick();
    in_inst   = mkw(3'd7, 3'd1, 8'hB2, 3'd0, 8'h00, 3'd0, 8'h00);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("fl1_valid", 64'(out_valid),  64'd0);
    check("fl1_count", 64'(inst_count), 64'd105);
    tick();
    out_ready = 1'b0;
    check("fl1_gone",  64'(out_valid),  64'd0);

    // ---------------- hazard ----------------
    in_valid = 1'b1;
    in_inst  = mkw(3'd1, 3'd3, 8'd7, 3'd0, 8'h00, 3'd0, 8'h00);  // A
    tick();
    check("hz_a", 64'(hazard), 64'd0);
    in_inst   = mkw(3'd2, 3'd0, 8'h00, 3'd0, 8'h00, 3'd3, 8'd7); // B hits A
    out_ready = 1'b1;
    tick();
    check("hz_b_fn",  64'(fn),     64'd2);
    check("hz_b_hit", 64'(hazard), 64'(HZ_ON));
    in_inst  = mkw(3'd1, 3'd3, 8'd7, 3'd0, 8'h00, 3'd0, 8'h00);  // A again
    tick();
    check("hz_a2",    64'(hazard), 64'd0);
    in_inst  = mkw(3'd3, 3'd0, 8'h00, 3'd0, 8'h00, 3'd3, 8'd8);  // index differs
    tick();
    in_valid = 1'b0;
    check("hz_b2_fn",   64'(fn),     64'd3);
    check("hz_b2_miss", 64'(hazard), 64'd0);
    tick();
    out_ready = 1'b0;
    check("hz_count", 64'(inst_count), 64'd109);

    // ---------------- async reset mid-operation ----------------
    in_valid = 1'b1;
    in_inst  = mkw(3'd5, 3'd2, 8'h55, 3'd1, 8'h11, 3'd0, 8'h00);
    tick();
    tick();
    in_valid = 1'b0;
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("ar_valid",   64'(out_valid),  64'd0);
    check("ar_fn",      64'(fn),         64'd0);
    check("ar_src_v",   64'(src_v),      64'd0);
    check("ar_count",   64'(inst_count), 64'd0);
    #3 rstn = 1'b1;
    tick();
    check("ar_ready",   64'(in_ready),   64'd1);
    check("ar_empty",   64'(out_valid),  64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
